// File: rtl/xnor_acc_pe_array.sv
// Binary PE array: per-beat XNOR-popcount per PE, saturating per-vector accumulation,
// then a clamped signed dot product and a thresholded activation bit per PE.
module xnor_acc_pe_array #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int WORD_SIZE = 64,
  parameter int ACC_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    weights_in_flat,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    activations_in_flat,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    valid_mask_flat,
  input  logic [ACC_W-1:0]                  thresh_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ROWS*COLS*ACC_W-1:0]        dots_out_flat,
  output logic [ROWS*COLS-1:0]              bits_out,
  output logic                              out_sat
);

  localparam int NPE = ROWS * COLS;
  localparam int PCW = $clog2(WORD_SIZE + 1);
  localparam logic signed [ACC_W+1:0] DMAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] DMIN = {3'b111, {(ACC_W-1){1'b0}}};

  logic                    stall;
  logic [PCW-1:0]          pop_c [NPE];
  logic [PCW-1:0]          nv_c  [NPE];

  logic                    s1_valid;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_thresh;
  logic [PCW-1:0]          s1_pop [NPE];
  logic [PCW-1:0]          s1_nv  [NPE];

  logic [ACC_W-1:0]        pacc [NPE];
  logic [ACC_W-1:0]        nacc [NPE];
  logic                    sat;

  logic [ACC_W-1:0]        pnext [NPE];
  logic [ACC_W-1:0]        nnext [NPE];
  logic signed [ACC_W-1:0] dot_c [NPE];
  logic [NPE-1:0]          bit_c;
  logic                    sat_acc;
  logic                    sat_clamp;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    for (int unsigned i = 0; i < NPE; i++) begin
      pop_c[i] = '0;
      nv_c[i]  = '0;
      for (int unsigned b = 0; b < WORD_SIZE; b++) begin
        pop_c[i] = pop_c[i] + PCW'(~(weights_in_flat[i*WORD_SIZE+b] ^ activations_in_flat[i*WORD_SIZE+b])
                                   & valid_mask_flat[i*WORD_SIZE+b]);
        nv_c[i]  = nv_c[i] + PCW'(valid_mask_flat[i*WORD_SIZE+b]);
      end
    end
  end

  // Dot is formed from the already-saturated sums, so a last beat folds in without a bubble.
  always_comb begin
    logic [ACC_W:0]          ps;
    logic [ACC_W:0]          ns;
    logic signed [ACC_W+1:0] dw;
    sat_acc   = 1'b0;
    sat_clamp = 1'b0;
    bit_c     = '0;
    for (int unsigned i = 0; i < NPE; i++) begin
      ps = {1'b0, pacc[i]} + (ACC_W+1)'(s1_pop[i]);
      ns = {1'b0, nacc[i]} + (ACC_W+1)'(s1_nv[i]);
      if (ps[ACC_W]) begin
        pnext[i] = '1;
        sat_acc  = 1'b1;
      end else begin
        pnext[i] = ps[ACC_W-1:0];
      end
      if (ns[ACC_W]) begin
        nnext[i] = '1;
        sat_acc  = 1'b1;
      end else begin
        nnext[i] = ns[ACC_W-1:0];
      end
      dw = signed'({1'b0, pnext[i], 1'b0}) - signed'({2'b00, nnext[i]});
      if (dw > DMAX) begin
        dot_c[i]  = DMAX[ACC_W-1:0];
        sat_clamp = 1'b1;
      end else if (dw < DMIN) begin
        dot_c[i]  = DMIN[ACC_W-1:0];
        sat_clamp = 1'b1;
      end else begin
        dot_c[i]  = dw[ACC_W-1:0];
      end
      bit_c[i] = (dot_c[i] >= s1_thresh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_thresh     <= '0;
      sat           <= 1'b0;
      out_valid     <= 1'b0;
      dots_out_flat <= '0;
      bits_out      <= '0;
      out_sat       <= 1'b0;
      for (int unsigned i = 0; i < NPE; i++) begin
        s1_pop[i] <= '0;
        s1_nv[i]  <= '0;
        pacc[i]   <= '0;
        nacc[i]   <= '0;
      end
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_last   <= in_valid && in_last;
      out_valid <= s1_valid && s1_last;
      if (in_valid) begin
        for (int unsigned i = 0; i < NPE; i++) begin
          s1_pop[i] <= pop_c[i];
          s1_nv[i]  <= nv_c[i];
        end
        if (in_last) s1_thresh <= thresh_in;
      end
      if (s1_valid) begin
        if (s1_last) begin
          for (int unsigned i = 0; i < NPE; i++) begin
            dots_out_flat[i*ACC_W +: ACC_W] <= dot_c[i];
            pacc[i] <= '0;
            nacc[i] <= '0;
          end
          bits_out <= bit_c;
          out_sat  <= sat || sat_acc || sat_clamp;
          sat      <= 1'b0;
        end else begin
          for (int unsigned i = 0; i < NPE; i++) begin
            pacc[i] <= pnext[i];
            nacc[i] <= nnext[i];
          end
          sat <= sat || sat_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_acc_pe_array.sv
// Directed bench for xnor_acc_pe_array with a 2x2 array of 8-bit words and 8-bit accumulators.
module tb_xnor_acc_pe_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] weights_in_flat;
  logic [31:0] activations_in_flat;
  logic [31:0] valid_mask_flat;
  logic [7:0]  thresh_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dots_out_flat;
  logic [3:0]  bits_out;
  logic        out_sat;

  int n_checks = 0;
  int n_errors = 0;

  xnor_acc_pe_array #(.ROWS(2), .COLS(2), .WORD_SIZE(8), .ACC_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_last             (in_last),
    .weights_in_flat     (weights_in_flat),
    .activations_in_flat (activations_in_flat),
    .valid_mask_flat     (valid_mask_flat),
    .thresh_in           (thresh_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .dots_out_flat       (dots_out_flat),
    .bits_out            (bits_out),
    .out_sat             (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rep(input logic [7:0] b);
    return {4{b}};
  endfunction

  // Presents one beat and lets the next rising edge take it.
  task automatic drive_beat(input logic [31:0] w, input logic [31:0] a, input logic [31:0] m,
                            input logic last, input logic [7:0] th);
    weights_in_flat     = w;
    activations_in_flat = a;
    valid_mask_flat     = m;
    in_last             = last;
    thresh_in           = th;
    in_valid            = 1'b1;
    chk("accept_ready", in_ready, 1'b1);
    tick();
  endtask

  task automatic idle;
    in_valid            = 1'b0;
    in_last             = 1'b1;
    thresh_in           = 8'h80;
    weights_in_flat     = '1;
    activations_in_flat = '1;
    valid_mask_flat     = '1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dots", dots_out_flat, 32'h0);
    chk("rst_bits", bits_out, 4'h0);
    chk("rst_sat", out_sat, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    // idle cycles with garbage last/thresh must not create a result
    tick();
    tick();
    chk("idle_no_result", out_valid, 1'b0);

    // single beat, all match
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b1, 8'h00);
    idle();
    chk("s1_latency_t1", out_valid, 1'b0);
    tick();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_dots", dots_out_flat, 32'h08080808);
    chk("s1_bits", bits_out, 4'hF);
    chk("s1_sat", out_sat, 1'b0);
    tick();
    chk("s1_consumed", out_valid, 1'b0);

    // three beats, pop 4 of 8 each
    drive_beat(rep(8'h0F), rep(8'h00), rep(8'hFF), 1'b0, 8'h7F);
    drive_beat(rep(8'h0F), rep(8'h00), rep(8'hFF), 1'b0, 8'h7F);
    drive_beat(rep(8'h0F), rep(8'h00), rep(8'hFF), 1'b1, 8'h01);
    idle();
    chk("m3_not_yet", out_valid, 1'b0);
    tick();
    chk("m3_valid", out_valid, 1'b1);
    chk("m3_dots", dots_out_flat, 32'h00000000);
    chk("m3_bits", bits_out, 4'h0);
    tick();

    // mask: only low nibble participates
    drive_beat(rep(8'hF0), rep(8'h00), rep(8'h0F), 1'b1, 8'h05);
    idle();
    tick();
    chk("mask_valid", out_valid, 1'b1);
    chk("mask_dots", dots_out_flat, 32'h04040404);
    chk("mask_bits", bits_out, 4'h0);
    tick();

    // distinct PEs: 8, nv=0 -> 0, -8, 4 with thresh 0
    drive_beat({8'h0F, 8'hFF, 8'h5A, 8'hFF}, {8'h0F, 8'h00, 8'hA5, 8'hFF},
               {8'h3C, 8'hFF, 8'h00, 8'hFF}, 1'b1, 8'h00);
    idle();
    tick();
    chk("pe_valid", out_valid, 1'b1);
    chk("pe_dots", dots_out_flat, 32'h04F80008);
    chk("pe_bits", bits_out, 4'b1011);
    tick();

    // backpressure: A pending, B queued in S1
    out_ready = 1'b0;
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b1, 8'h00);
    drive_beat(rep(8'hF0), rep(8'h00), rep(8'h0F), 1'b1, 8'h05);
    idle();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_dots", dots_out_flat, 32'h08080808);
      chk("bp_hold_bits", bits_out, 4'hF);
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    chk("bp_b_valid", out_valid, 1'b1);
    chk("bp_b_dots", dots_out_flat, 32'h04040404);
    chk("bp_b_bits", bits_out, 4'h0);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // back-to-back single-beat vectors
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b1, 8'h00);
    drive_beat(rep(8'hF0), rep(8'h00), rep(8'h0F), 1'b1, 8'h05);
    chk("b2b_r0_valid", out_valid, 1'b1);
    chk("b2b_r0_dots", dots_out_flat, 32'h08080808);
    drive_beat(rep(8'h0F), rep(8'h00), rep(8'hFF), 1'b1, 8'h00);
    idle();
    chk("b2b_r1_valid", out_valid, 1'b1);
    chk("b2b_r1_dots", dots_out_flat, 32'h04040404);
    chk("b2b_r1_bits", bits_out, 4'h0);
    tick();
    chk("b2b_r2_valid", out_valid, 1'b1);
    chk("b2b_r2_dots", dots_out_flat, 32'h00000000);
    chk("b2b_r2_bits", bits_out, 4'hF);
    tick();
    chk("b2b_drained", out_valid, 1'b0);

    // saturation: 40 beats of pop 8 overflow the 8-bit accumulators
    for (int i = 0; i < 40; i++)
      drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), (i == 39), 8'h00);
    idle();
    tick();
    chk("sat_valid", out_valid, 1'b1);
    chk("sat_dots", dots_out_flat, 32'h7F7F7F7F);
    chk("sat_bits", bits_out, 4'hF);
    chk("sat_flag", out_sat, 1'b1);
    tick();
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b1, 8'h00);
    idle();
    tick();
    chk("sat_next_dots", dots_out_flat, 32'h08080808);
    chk("sat_next_flag", out_sat, 1'b0);
    tick();

    // reset mid-vector discards the partial sum
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b0, 8'h00);
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b0, 8'h00);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", out_valid, 1'b0);
    drive_beat(rep(8'hFF), rep(8'hFF), rep(8'hFF), 1'b1, 8'h00);
    idle();
    tick();
    chk("mrst_valid", out_valid, 1'b1);
    chk("mrst_dots", dots_out_flat, 32'h08080808);
    chk("mrst_sat", out_sat, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
